// File: rtl/tdm_demux_4_to_1.sv
// Receive side of a 4-channel TDM link: aligns on the slot-0 sync marker and
// rebuilds the four channel words. Optional frame counter: TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux_4_to_1 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din_valid,
  input  logic [WIDTH-1:0]     din,
  input  logic                 sync,
  output logic [4*WIDTH-1:0]   dout,
  output logic                 frame_valid,
  output logic                 locked,
  output logic [1:0]           slot,
`ifdef TDM_DEMUX_FRAME_CNT_EN
  output logic [7:0]           frame_cnt,
`endif
  output logic                 sync_err
);

  localparam int unsigned DOUT_W = 4 * WIDTH;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_slot;
  logic [WIDTH-1:0]   r_shadow0;
  logic [WIDTH-1:0]   r_shadow1;
  logic [WIDTH-1:0]   r_shadow2;
  logic [DOUT_W-1:0]  r_dout;
  logic               r_frame_valid;
  logic               r_sync_err;
  logic               r_locked;
  logic [CNT_W-1:0]   r_frame_cnt;

  // Alignment FSM, shadow capture and atomic frame publication
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_slot        <= 2'd0;
      r_shadow0     <= '0;
      r_shadow1     <= '0;
      r_shadow2     <= '0;
      r_dout        <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
      if (din_valid) begin
        unique case (r_state)
          ST_HUNT: begin
            if (sync) begin
              r_shadow0 <= din;
              r_slot    <= 2'd1;
              r_state   <= ST_LOCKED;
              r_locked  <= 1'b1;
            end
          end
          ST_LOCKED: begin
            if (sync) begin
              // An early sync drops the partial frame and restarts at slot 0
              if (r_slot != 2'd0) begin
                r_sync_err <= 1'b1;
              end
              r_shadow0 <= din;
              r_slot    <= 2'd1;
            end else begin
              unique case (r_slot)
                2'd0: begin
                  r_sync_err <= 1'b1;
                  r_state    <= ST_HUNT;
                  r_locked   <= 1'b0;
                  r_slot     <= 2'd0;
                end
                2'd1: begin
                  r_shadow1 <= din;
                  r_slot    <= 2'd2;
                end
                2'd2: begin
                  r_shadow2 <= din;
                  r_slot    <= 2'd3;
                end
                2'd3: begin
                  r_dout        <= {din, r_shadow2, r_shadow1, r_shadow0};
                  r_frame_valid <= 1'b1;
                  r_slot        <= 2'd0;
                  r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
                end
                default: begin
                  r_slot <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            r_state <= ST_HUNT;
          end
        endcase
      end
    end
  end

  assign dout        = r_dout;
  assign frame_valid = r_frame_valid;
  assign locked      = r_locked;
  assign slot        = r_slot;
  assign sync_err    = r_sync_err;

`ifdef TDM_DEMUX_FRAME_CNT_EN
  assign frame_cnt = r_frame_cnt;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = ^r_frame_cnt;
`endif

endmodule

// File: tb/tb_tdm_demux_4_to_1.sv
// Self-checking bench for tdm_demux_4_to_1: directed scenarios followed by
// random beats, all compared against a frame-queue reference model.
module tb_tdm_demux_4_to_1;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             din_valid;
  logic [WIDTH-1:0] din;
  logic             sync;
  logic [15:0]      dout;
  logic             frame_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  tdm_demux_4_to_1 #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .sync        (sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
`ifdef TDM_DEMUX_FRAME_CNT_EN
    .frame_cnt   (frame_cnt),
`endif
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int fv_seen  = 0;

  // Reference model: beats of the frame in progress, plus published state
  logic [3:0]  m_q[$];
  bit          m_locked;
  logic [15:0] m_dout;
  bit          m_fv;
  bit          m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_locked = 1'b0;
    m_dout   = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic model_beat(input bit v, input bit s, input logic [3:0] d);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (v) begin
      if (s) begin
        m_err = m_locked && (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (m_q.size() == 0) begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end else begin
          m_q.push_back(d);
          if (m_q.size() == 4) begin
            m_dout = {m_q[3], m_q[2], m_q[1], m_q[0]};
            m_fv   = 1'b1;
            m_cnt  = (m_cnt + 1) % 256;
            m_q.delete();
          end
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ".dout"},        32'(dout),        32'(m_dout));
    chk({where, ".frame_valid"}, 32'(frame_valid), 32'(m_fv));
    chk({where, ".sync_err"},    32'(sync_err),    32'(m_err));
    chk({where, ".locked"},      32'(locked),      32'(m_locked));
    chk({where, ".slot"},        32'(slot),        32'(m_q.size()));
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk({where, ".frame_cnt"},   32'(frame_cnt),   32'(m_cnt));
`endif
    if (frame_valid === 1'b1) fv_seen++;
  endtask

  task automatic beat(input bit v, input bit s, input logic [3:0] d, input string where);
    @(negedge clk);
    din_valid = v;
    sync      = s;
    din       = d;
    model_beat(v, s, d);
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  // Reset is asserted together with a live sync beat, which must be ignored
  task automatic do_reset(input string where);
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b1;
    sync      = 1'b1;
    din       = 4'($urandom);
    model_reset();
    @(posedge clk);
    #1;
    check_all(where);
    @(negedge clk);
    reset     = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic frame(input logic [3:0] a, b, c, d, input string where);
    beat(1'b1, 1'b1, a, where);
    beat(1'b1, 1'b0, b, where);
    beat(1'b1, 1'b0, c, where);
    beat(1'b1, 1'b0, d, where);
  endtask

  initial begin
    reset     = 1'b1;
    din_valid = 1'b0;
    sync      = 1'b0;
    din       = '0;
    model_reset();
    repeat (2) @(posedge clk);

    do_reset("reset");
    chk("reset.dout_zero", 32'(dout), 32'h0);

    // Basic frame
    frame(4'hA, 4'hB, 4'hC, 4'hD, "basic");
    chk("basic.dout_lit", 32'(dout), 32'hDCBA);
    chk("basic.fv_lit", 32'(frame_valid), 32'h1);
    chk("basic.slot_lit", 32'(slot), 32'h0);
    chk("basic.locked_lit", 32'(locked), 32'h1);
    beat(1'b0, 1'b0, 4'h0, "basic_idle");

    // Beats before the first sync are dropped silently
    do_reset("hunt_rst");
    beat(1'b1, 1'b0, 4'h1, "hunt_discard");
    beat(1'b1, 1'b0, 4'h2, "hunt_discard");
    chk("hunt.locked_lit", 32'(locked), 32'h0);
    frame(4'h5, 4'h6, 4'h7, 4'h8, "hunt_frame");
    chk("hunt.dout_lit", 32'(dout), 32'h8765);

    // Gapped input: idle cycles carry random din/sync which must be ignored
    do_reset("gap_rst");
    fv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v4 [4];
      v4[0] = 4'hA; v4[1] = 4'hB; v4[2] = 4'hC; v4[3] = 4'hD;
      beat(1'b1, (i == 0), v4[i], "gap_beat");
      for (int g = 0; g < 3; g++) beat(1'b0, 1'($urandom), 4'($urandom), "gap_idle");
    end
    chk("gap.dout_lit", 32'(dout), 32'hDCBA);
    chk("gap.fv_once", 32'(fv_seen), 32'h1);

    // Early sync
    do_reset("early_rst");
    beat(1'b1, 1'b1, 4'h1, "early");
    beat(1'b1, 1'b0, 4'h2, "early");
    beat(1'b1, 1'b1, 4'h3, "early_sync");
    chk("early.err_lit", 32'(sync_err), 32'h1);
    chk("early.dout_kept", 32'(dout), 32'h0);
    chk("early.locked_lit", 32'(locked), 32'h1);
    beat(1'b1, 1'b0, 4'h4, "early");
    beat(1'b1, 1'b0, 4'h5, "early");
    beat(1'b1, 1'b0, 4'h6, "early");
    chk("early.dout_lit", 32'(dout), 32'h6543);

    // Missing sync at slot 0
    beat(1'b1, 1'b0, 4'h9, "missing");
    chk("missing.err_lit", 32'(sync_err), 32'h1);
    chk("missing.locked_lit", 32'(locked), 32'h0);
    chk("missing.slot_lit", 32'(slot), 32'h0);
    chk("missing.dout_kept", 32'(dout), 32'h6543);
    beat(1'b0, 1'b0, 4'h0, "missing_idle");

    // Reset mid-frame
    beat(1'b1, 1'b1, 4'hE, "midrst");
    beat(1'b1, 1'b0, 4'hF, "midrst");
    do_reset("midrst_rst");
    chk("midrst.slot_lit", 32'(slot), 32'h0);
    chk("midrst.locked_lit", 32'(locked), 32'h0);
    frame(4'h1, 4'h2, 4'h3, 4'h4, "midrst_frame");
    chk("midrst.dout_lit", 32'(dout), 32'h4321);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("cnt.one", 32'(frame_cnt), 32'h1);
    for (int f = 0; f < 255; f++)
      frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), "cnt_wrap");
    chk("cnt.wrap", 32'(frame_cnt), 32'h0);
`endif

    // Random traffic against the model
    do_reset("rand_rst");
    for (int i = 0; i < 1500; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (!m_locked)            s = ($urandom_range(0, 2) == 0);
      else if (m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
      else                      s = ($urandom_range(0, 11) == 0);
      beat(v, s, 4'($urandom), "rand");
      if (m_fv && m_err) chk("rand.fv_err_excl", 32'h1, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
